isp8_mbyte_seq: RTL
===================

Name: isp8_mbyte_seq

Overview:
- Multi-byte arithmetic sequencer for the isp8 8-bit ALU.
- Runs an N-byte add, subtract or compare LSB-first, one byte per clock, through the shared 8-bit adder.
- Drives the ALU control inputs (sub/subc/addc/cmp, opcode field, carry-in).
- Steps register-file read and write addresses, and accumulates the final carry and zero flags.
- Sits beside the core's decode logic. It owns the ALU controls only while busy=1.

Parameters:
- MAX_BYTES, 4, largest legal operand length in bytes (1..7).
- AW, 5, register-file address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- abort  in  1  synchronous cancel
- op  in  2  00=add, 01=sub, 10=cmp, 11=reserved (treated as cmp)
- nbytes  in  3  operand length in bytes
- rd_base  in  AW  LSB address of destination/first operand
- rb_base  in  AW  LSB address of second operand
- rd_addr  out  AW  register-file read address A
- rb_addr  out  AW  register-file read address B
- wr_en  out  1  register-file write strobe
- wr_addr  out  AW  write address
- wr_data  out  8  write data (equals alu_dout)
- alu_instr  out  18  opcode to ALU
- alu_sub, alu_subc, alu_addc, alu_cmp  out  1 each  ALU mode controls
- alu_carry  out  1  ALU carry_flag input
- alu_dout  in  8  ALU result
- alu_cout  in  1  ALU carry out (borrow for sub/cmp)
- busy  out  1  sequencer owns ALU
- done  out  1  one-cycle completion pulse
- flag_c  out  1  final carry/borrow
- flag_z  out  1  1 when all result bytes were zero

Behaviour:
- Clock and reset: single clock domain, reset asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE; idx=0; busy=0; done=0; wr_en=0.
  - flag_c=0; flag_z=0; alu_instr=0; all alu_* controls=0.
  - rd_addr=rb_addr=wr_addr=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0; all alu_* outputs forced 0.
  - On start: latch op, nbytes, rd_base and rb_base; idx<=0; zacc<=1.
  - If nbytes is 0 or greater than MAX_BYTES, go to DONE with flags unchanged and no writes.
  - Otherwise go to RUN.
- RUN:
  - busy=1. Each cycle processes byte idx.
  - Addresses: rd_addr=rd_base+idx, rb_addr=rb_base+idx, both mod 2^AW (wrap). Register-file read is combinational in the same cycle.
  - alu_instr[17:14]=4'b0000 (add/sub result path); all other bits 0.
  - First byte (idx=0):
    - add: addc=0, carry-in 0.
    - sub: alu_sub=1.
    - cmp: alu_cmp=1.
  - Later bytes:
    - add: alu_addc=1.
    - sub and cmp: alu_subc=1.
    - alu_carry=creg, where creg is the registered alu_cout of the previous byte.
  - Writes: wr_en=1 with wr_addr=rd_addr for add and sub. wr_en=0 for cmp.
  - Each cycle: creg<=alu_cout; zacc<=zacc & (alu_dout==0); idx<=idx+1.
  - After byte nbytes-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - flag_c<=creg and flag_z<=zacc are registered on entry, so they are valid from the done cycle and held until the next completed operation.
  - Next state is IDLE.
- Latency: start at cycle 0 → bytes at cycles 1..n → done at cycle n+1.
- start while busy or in DONE: ignored, not queued.
- abort:
  - In RUN: next state IDLE, no done, flags unchanged. Writes of bytes already issued stand.
  - abort takes priority over completion.
  - In IDLE or DONE: no effect.
- Reset mid-operation: immediate return to IDLE with reset values; partial writes are not undone.
- Carry convention is borrow for sub/cmp: flag_c=1 means borrow occurred.

Test Plan:
- Reset mid-RUN of a 4-byte add → busy, wr_en and all alu_* outputs drop to 0 asynchronously; done never pulses; flags are 0.
- add, nbytes=2, rd=0x01FF, rb=0x0001 → writes 0x00 then 0x02; result 0x0200; flag_c=0, flag_z=0; done at cycle 3.
- sub, nbytes=2, rd=0x0000, rb=0x0001 → result 0xFFFF; flag_c=1, flag_z=0. Byte 1 shows alu_subc=1 and alu_carry=1.
- cmp, nbytes=4, both operands 0x12345678 → wr_en never asserted; flag_z=1, flag_c=0; done at cycle 5.
- add, nbytes=3, rd_base=31 (AW=5) → rd_addr sequence 31, 0, 1; a start pulse issued during RUN is ignored. nbytes=0 → done next cycle with no writes and flags unchanged.
- abort asserted on byte 2 of a 4-byte sub → bytes 0–1 written; no done pulse; flags keep their previous values; the FSM accepts a new start on the following cycle.

Source files
------------

// File: rtl/isp8_mbyte_seq.sv
// Multi-byte add/sub/compare sequencer for the isp8 8-bit ALU.
// Processes one operand byte per clock, LSB first, and accumulates carry/zero flags.
module isp8_mbyte_seq #(
    parameter int MAX_BYTES = 4,
    parameter int AW        = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    op,
    input  logic [2:0]    nbytes,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] rb_base,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] rb_addr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [17:0]   alu_instr,
    output logic          alu_sub,
    output logic          alu_subc,
    output logic          alu_addc,
    output logic          alu_cmp,
    output logic          alu_carry,
    input  logic [7:0]    alu_dout,
    input  logic          alu_cout,
    output logic          busy,
    output logic          done,
    output logic          flag_c,
    output logic          flag_z
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] MAXB = 3'(MAX_BYTES);

    state_t        state, state_nx;
    logic [2:0]    idx;
    logic [2:0]    n_q;
    logic [1:0]    op_q;
    logic [AW-1:0] rd_base_q;
    logic [AW-1:0] rb_base_q;
    logic          creg;
    logic          zacc;

    logic is_add, is_cmp, first, last, len_ok, res_zero;

    assign is_add   = (op_q == 2'b00);
    assign is_cmp   = op_q[1];           // 11 behaves as compare
    assign first    = (idx == 3'd0);
    assign last     = (idx == n_q - 3'd1);
    assign len_ok   = (nbytes != 3'd0) && (nbytes <= MAXB);
    assign res_zero = (alu_dout == 8'h00);

    assign wr_data   = alu_dout;
    // Opcode field is all zeros in RUN (add/sub result path) and forced zero elsewhere.
    assign alu_instr = 18'd0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = len_ok ? RUN : DONE;
            RUN:     if (abort) state_nx = IDLE;
                     else if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        rd_addr   = '0;
        rb_addr   = '0;
        wr_addr   = '0;
        wr_en     = 1'b0;
        alu_sub   = 1'b0;
        alu_subc  = 1'b0;
        alu_addc  = 1'b0;
        alu_cmp   = 1'b0;
        alu_carry = 1'b0;
        case (state)
            RUN: begin
                busy    = 1'b1;
                rd_addr = rd_base_q + AW'(idx);
                rb_addr = rb_base_q + AW'(idx);
                wr_addr = rd_addr;
                // The byte presented in an aborted cycle is not committed.
                wr_en   = !is_cmp && !abort;
                if (first) begin
                    alu_sub = !is_add && !is_cmp;
                    alu_cmp = is_cmp;
                end else begin
                    alu_addc  = is_add;
                    alu_subc  = !is_add;
                    alu_carry = creg;
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            n_q       <= '0;
            op_q      <= '0;
            rd_base_q <= '0;
            rb_base_q <= '0;
            creg      <= 1'b0;
            zacc      <= 1'b0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    op_q      <= op;
                    n_q       <= nbytes;
                    rd_base_q <= rd_base;
                    rb_base_q <= rb_base;
                    idx       <= '0;
                    zacc      <= 1'b1;
                    creg      <= 1'b0;
                end
                RUN: begin
                    creg <= alu_cout;
                    zacc <= zacc & res_zero;
                    idx  <= idx + 3'd1;
                    // Flags take the last byte's results as DONE is entered.
                    if (!abort && last) begin
                        flag_c <= alu_cout;
                        flag_z <= zacc & res_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
